// File: rtl/ascii7_uart_rx_pkg.sv
// rtl/ascii7_uart_rx_pkg.sv - shared state encodings, ASCII constants and parity helper
//
// Purpose: definitions shared by the ASCII UART receiver, the character-sequence
//          detectors downstream of it, and their benches.
// Contents:
//   ST_*         receiver FSM state encodings
//   rx_state_e   enum built on those encodings
//   ASCII_*      characters the detectors look for
//   parity_ok()  parity check over seven data bits plus the parity bit

package ascii7_uart_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP,
    BREAK  = ST_BREAK
  } rx_state_e;

  localparam logic [6:0] ASCII_C = 7'h43;
  localparam logic [6:0] ASCII_O = 7'h4F;
  localparam logic [6:0] ASCII_R = 7'h52;
  localparam logic [6:0] ASCII_N = 7'h4E;
  localparam logic [6:0] ASCII_A = 7'h41;

  // The XOR over data and parity bit is 0 for a good even-parity frame and 1
  // for a good odd-parity frame, so it is compared directly against `odd`.
  function automatic logic parity_ok(input logic [6:0] data,
                                     input logic       pbit,
                                     input logic       odd);
    return ((^{data, pbit}) == odd);
  endfunction

endpackage

// File: rtl/ascii7_uart_rx_sync.sv
// rtl/ascii7_uart_rx_sync.sv - two-flop synchroniser for the serial line
//
// Purpose: brings the asynchronous rxd line into the clk domain.
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset; both flops reset to 1 (idle line)
//   d    in   asynchronous input
//   q    out  synchronised output, two clk cycles behind d

module ascii7_uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ascii7_uart_rx.sv
// rtl/ascii7_uart_rx.sv - UART receiver delivering 7-bit ASCII characters
//
// Purpose: receives asynchronous UART frames (start, 7 data bits LSB first,
//          optional parity, stop) and presents each good character with a
//          one-cycle strobe. Bad frames are dropped with an error strobe.
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit, 4..1024
//   PARITY_EN     1 = frame carries a parity bit
//   PARITY_ODD    1 = odd parity, 0 = even parity
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   rxd         in   asynchronous serial line, idle high
//   char_out    out  last good character; stable between char_valid strobes
//   char_valid  out  one-cycle strobe, char_out updated this cycle
//   parity_err  out  one-cycle strobe, parity mismatch, character dropped
//   frame_err   out  one-cycle strobe, stop bit low, character dropped
//   busy        out  high from a confirmed start bit until return to IDLE

module ascii7_uart_rx
  import ascii7_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [6:0] char_out,
  output logic       char_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  // Start bit is checked half a bit in; every later bit is sampled one full
  // bit after the previous sample, which lands each sample mid-bit.
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic rxs;

  ascii7_uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    idx_q,   idx_d;
  logic [6:0]    data_q,  data_d;
  logic          perr_q,  perr_d;
  logic [6:0]    char_q,  char_d;
  logic          cv_q,    cv_d;
  logic          pe_q,    pe_d;
  logic          fe_q,    fe_d;
  logic          busy_q,  busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    data_d  = data_q;
    perr_d  = perr_q;
    char_d  = char_q;
    cv_d    = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = DATA;
            busy_d  = 1'b1;
            idx_d   = 3'd0;
            perr_d  = 1'b0;
          end else begin
            // Line went back high before mid-start: a glitch, not a frame.
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d         = '0;
          data_d[idx_q] = rxs;
          if (idx_q == 3'd6) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          perr_d  = !parity_ok(data_q, rxs, PARITY_ODD);
          state_d = STOP;
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          busy_d = 1'b0;
          if (rxs) begin
            state_d = IDLE;
            if (perr_q) begin
              pe_d = 1'b1;
            end else begin
              cv_d   = 1'b1;
              char_d = data_q;
            end
          end else begin
            // Low stop bit outranks any pending parity error; BREAK then
            // swallows the rest of a held-low line so only one error fires.
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end
      end

      BREAK: begin
        cnt_d = '0;
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      data_q  <= 7'h00;
      perr_q  <= 1'b0;
      char_q  <= 7'h00;
      cv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      char_q  <= char_d;
      cv_q    <= cv_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      busy_q  <= busy_d;
    end
  end

  assign char_out   = char_q;
  assign char_valid = cv_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ascii7_uart_rx.sv
// tb/tb_ascii7_uart_rx.sv - directed self-checking bench for ascii7_uart_rx

module tb_ascii7_uart_rx;
  import ascii7_uart_rx_pkg::*;

  localparam int CPB   = 16;
  localparam int LAT_A = 3 + CPB / 2 + 9 * CPB;  // parity frame, rxd low to strobe seen
  localparam int LAT_B = 3 + CPB / 2 + 8 * CPB;  // no-parity frame

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd_a, rxd_b;
  logic [6:0] char_out_a, char_out_b;
  logic       char_valid_a, char_valid_b;
  logic       parity_err_a, parity_err_b;
  logic       frame_err_a, frame_err_b;
  logic       busy_a, busy_b;

  ascii7_uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd_a),
    .char_out   (char_out_a),
    .char_valid (char_valid_a),
    .parity_err (parity_err_a),
    .frame_err  (frame_err_a),
    .busy       (busy_a)
  );

  ascii7_uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd_b),
    .char_out   (char_out_b),
    .char_valid (char_valid_b),
    .parity_err (parity_err_b),
    .frame_err  (frame_err_b),
    .busy       (busy_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  int         cv_a = 0, pe_a = 0, fe_a = 0, busy_cyc_a = 0;
  int         cv_b = 0, pe_b = 0, fe_b = 0;
  int         multi = 0;
  int         last_cv_cyc_b = 0;
  logic [6:0] chars_a[$];
  int         cycs_a[$];

  always @(negedge clk) begin
    if (char_valid_a) begin
      cv_a <= cv_a + 1;
      chars_a.push_back(char_out_a);
      cycs_a.push_back(cyc);
    end
    if (parity_err_a) pe_a <= pe_a + 1;
    if (frame_err_a)  fe_a <= fe_a + 1;
    if (busy_a)       busy_cyc_a <= busy_cyc_a + 1;
    if (char_valid_b) begin
      cv_b <= cv_b + 1;
      last_cv_cyc_b <= cyc;
    end
    if (parity_err_b) pe_b <= pe_b + 1;
    if (frame_err_b)  fe_b <= fe_b + 1;
    if ((int'(char_valid_a) + int'(parity_err_a) + int'(frame_err_a)) > 1 ||
        (int'(char_valid_b) + int'(parity_err_b) + int'(frame_err_b)) > 1)
      multi <= multi + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Caller is on a falling edge; returns on the falling edge one bit later.
  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else     rxd_a = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [6:0] d, input bit pen,
                      input bit pbit, input bit stopb);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 7; i++) drive_bit(sel, d[i]);
    if (pen) drive_bit(sel, pbit);
    drive_bit(sel, stopb);
  endtask

  logic [6:0] seq_c[6] = '{7'h43, 7'h4F, 7'h52, 7'h4F, 7'h4E, 7'h41};
  bit         seq_p[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int t0, base_cv, base_pe, base_fe, base_busy, start_idx;

    rst   = 1'b1;
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_char_out",   32'(char_out_a),   32'h0);
    check_eq("reset_char_valid", 32'(char_valid_a), 32'h0);
    check_eq("reset_parity_err", 32'(parity_err_a), 32'h0);
    check_eq("reset_frame_err",  32'(frame_err_a),  32'h0);
    check_eq("reset_busy",       32'(busy_a),       32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single clean 'C' with latency check.
    base_cv = cv_a;
    t0 = cyc;
    send(1'b0, ASCII_C, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("c_count", 32'(cv_a - base_cv), 32'd1);
    check_eq("c_char", 32'(char_out_a), 32'h43);
    if (cycs_a.size() > 0) check_eq("c_latency", 32'(cycs_a[cycs_a.size()-1] - t0), 32'(LAT_A));
    else check_eq("c_latency_present", 32'(cycs_a.size()), 32'd1);

    // Back-to-back C O R O N A with no idle gap.
    start_idx = chars_a.size();
    base_cv = cv_a;
    for (int k = 0; k < 6; k++) send(1'b0, seq_c[k], 1'b1, seq_p[k], 1'b1);
    repeat (4) @(negedge clk);
    check_eq("b2b_count", 32'(cv_a - base_cv), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (start_idx + k < chars_a.size()) begin
        check_eq($sformatf("b2b_char%0d", k), 32'(chars_a[start_idx+k]), 32'(seq_c[k]));
        if (k > 0)
          check_eq($sformatf("b2b_gap%0d", k),
                   32'(cycs_a[start_idx+k] - cycs_a[start_idx+k-1]), 32'd160);
      end
    end

    // Parity fault: char_out must keep the preceding 'C'.
    send(1'b0, ASCII_C, 1'b1, 1'b1, 1'b1);
    base_cv = cv_a;
    base_pe = pe_a;
    send(1'b0, ASCII_A, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("par_err_count", 32'(pe_a - base_pe), 32'd1);
    check_eq("par_no_valid",  32'(cv_a - base_cv), 32'd0);
    check_eq("par_char_hold", 32'(char_out_a), 32'h43);

    // Framing fault followed by a 40-bit break.
    base_fe = fe_a;
    base_pe = pe_a;
    base_cv = cv_a;
    send(1'b0, ASCII_N, 1'b1, 1'b0, 1'b0);
    repeat (40 * CPB) @(negedge clk);
    check_eq("brk_busy_low", 32'(busy_a), 32'h0);
    rxd_a = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_eq("frm_err_count", 32'(fe_a - base_fe), 32'd1);
    check_eq("frm_no_valid",  32'(cv_a - base_cv), 32'd0);
    send(1'b0, ASCII_O, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("post_brk_count", 32'(cv_a - base_cv), 32'd1);
    check_eq("post_brk_char",  32'(char_out_a), 32'h4F);
    check_eq("post_brk_no_pe", 32'(pe_a - base_pe), 32'd0);

    // Start glitch of 5 cycles.
    base_busy = busy_cyc_a;
    base_cv = cv_a;
    base_pe = pe_a;
    base_fe = fe_a;
    rxd_a = 1'b0;
    repeat (5) @(negedge clk);
    rxd_a = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_eq("glitch_busy", 32'(busy_cyc_a - base_busy), 32'd0);
    check_eq("glitch_strobes", 32'((cv_a - base_cv) + (pe_a - base_pe) + (fe_a - base_fe)), 32'd0);

    // No-parity instance receives 'R'.
    t0 = cyc;
    send(1'b1, ASCII_R, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("np_count", 32'(cv_b), 32'd1);
    check_eq("np_char", 32'(char_out_b), 32'h52);
    check_eq("np_latency", 32'(last_cv_cyc_b - t0), 32'(LAT_B));
    check_eq("np_errs", 32'(pe_b + fe_b), 32'd0);

    // Reset during data bit 3.
    base_cv = cv_a;
    base_pe = pe_a;
    base_fe = fe_a;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, ASCII_N[i]);
    rxd_a = ASCII_N[3];
    repeat (CPB / 2) @(negedge clk);
    check_eq("rst_pre_busy", 32'(busy_a), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_busy",       32'(busy_a),       32'h0);
    check_eq("rst_char_out",   32'(char_out_a),   32'h0);
    check_eq("rst_char_valid", 32'(char_valid_a), 32'h0);
    rxd_a = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check_eq("rst_strobes", 32'((cv_a - base_cv) + (pe_a - base_pe) + (fe_a - base_fe)), 32'd0);
    send(1'b0, ASCII_N, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("post_rst_count", 32'(cv_a - base_cv), 32'd1);
    check_eq("post_rst_char",  32'(char_out_a), 32'h4E);

    check_eq("strobe_exclusive", 32'(multi), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ascii7_uart_rx.md
Name: ascii7_uart_rx

Overview:
Serial front end for the character-sequence detectors. It receives asynchronous UART frames on one line and recovers 7-bit ASCII characters. It delivers each good character on a 7-bit bus with a one-cycle valid strobe. Downstream detectors consume one character per strobe; this block is the only source of their character input.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 4..1024.
PARITY_EN, 1, 1 = frame carries a parity bit after the data; 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
rxd  input  1  asynchronous serial line; idle high.
char_out  output  7  last good character received, LSB-first assembled.
char_valid  output  1  one-cycle strobe: char_out was updated this cycle.
parity_err  output  1  one-cycle strobe: parity mismatch; character dropped.
frame_err  output  1  one-cycle strobe: stop bit sampled low; character dropped.
busy  output  1  high from a confirmed start bit until return to IDLE.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
- Reset values: char_out=7'h00, char_valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE, synchroniser flops=1.
- Assertion of rst mid-frame aborts the frame and emits no strobe.
- rxd passes through a 2-FF synchroniser; all logic uses the synchronised value rxs.
- Bit counter cnt has width $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2, floored. Data bit index is 3 bits, range 0..6.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: when rxs=0, go to START with cnt cleared.
- START: sample at cnt=HALF-1.
  - rxs=0: confirmed start; busy=1; go to DATA with cnt cleared.
  - rxs=1: treat as a glitch; return to IDLE; no strobe.
- DATA: sample at each cnt=CLKS_PER_BIT-1 and shift the sample into bit[idx]. After idx=6, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: sample at cnt=CLKS_PER_BIT-1. The check is ^{data,pbit} == PARITY_ODD; a mismatch latches a pending parity error.
- STOP: sample at cnt=CLKS_PER_BIT-1.
  - rxs=1 and no parity error: next cycle char_out<=data and char_valid=1; go to IDLE.
  - rxs=1 with parity error: next cycle parity_err=1; char_out holds its previous value; go to IDLE.
  - rxs=0: next cycle frame_err=1; frame_err takes priority over parity_err; go to BREAK.
- BREAK: stay until rxs=1, then go to IDLE. A held-low break line produces exactly one frame_err.
- busy drops to 0 in the same cycle as the strobe.
- Latency: the strobe fires HALF + (8+PARITY_EN)*CLKS_PER_BIT + 1 cycles after rxs first goes low, plus 2 synchroniser cycles from rxd.
- Strobe exclusivity: at most one of char_valid, parity_err or frame_err is high in any cycle. Each strobe lasts exactly one cycle.
- Back-to-back frames: a start bit directly after the stop bit is accepted. The FSM is in IDLE by mid-stop plus one cycle, so no start edge is missed.
- char_out is stable between strobes. Consumers must qualify it with char_valid.

Decomposition:
- Shared parameters include file holds:
  - the FSM state encodings as localparams;
  - the ASCII constants used by the detectors and benches: C=7'h43, O=7'h4F, R=7'h52, N=7'h4E, A=7'h41.
- One sub-module, rx_sync: a 2-FF synchroniser with asynchronous reset to 1.

Test Plan:
- Clean characters: PARITY_EN=1, even parity, CLKS_PER_BIT=16. Send 'C' (0x43, pbit 1) -> one char_valid pulse with char_out=7'h43, at the computed latency.
- Back-to-back sequence: send C,O,R,O,N,A with pbits 1,1,1,1,0,0 and no idle gap -> six char_valid pulses carrying 43,4F,52,4F,4E,41, spaced 160 cycles apart.
- Parity fault: send 0x41 with pbit=1 -> parity_err pulse, no char_valid, char_out unchanged from the previous character.
- Framing fault and break: send 0x4E with the stop bit low, then hold rxd low for 40 bit times -> exactly one frame_err pulse. The next clean frame is received correctly.
- Start glitch: pulse rxd low for 5 cycles -> FSM returns to IDLE, busy never asserts, no strobe. With PARITY_EN=0, 'R' is received correctly.
- Mid-frame reset: assert rst during data bit 3 -> all outputs 0 immediately and no strobe. A fresh frame after rst release is received correctly.
